spi_read_sequencer: RTL and testbench
=====================================

SPI_READ_SEQUENCER -- requirements
Module: spi_read_sequencer

Interface
REQ-001 Parameter REFRESH_PERIOD, default 40_000: clk cycles between read launches; legal values 2 or more.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum clk cycles in REQ waiting for d_ready; legal values 1 or more.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_l  input  1  asynchronous active-low reset.
REQ-005 en  input  1  high enables the refresh timer and read launches.
REQ-006 d_ready  input  1  level from SPI reader; high means d holds a completed 16-bit word.
REQ-007 d  input  16  SPI read data; sampled only in REQ with d_ready high.
REQ-008 err_clr  input  1  single-cycle pulse that clears timeout_err and overrun.
REQ-009 rd  output  1  read request to SPI reader; registered.
REQ-010 sample  output  16  last captured word; registered.
REQ-011 sample_valid  output  1  one-cycle pulse when sample updates.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 sample_cnt  output  8  captured-word count; wraps 255 to 0.
REQ-014 timeout_err  output  1  sticky; a request timed out.
REQ-015 overrun  output  1  sticky; a refresh tick arrived while not in IDLE.

Function
REQ-016 Timer counts 0 to REFRESH_PERIOD-1 while en=1, then wraps to 0; the wrap cycle is the tick.
REQ-017 en=0: timer holds at 0, no tick; the FSM finishes any transaction in progress.
REQ-018 FSM states: IDLE, REQ, CAPT, RELEASE.
REQ-019 IDLE: tick moves the FSM to REQ; rd goes high on the next edge.
REQ-020 REQ: rd=1; timeout counter increments each cycle from 0.
REQ-021 REQ with d_ready=1 sampled at edge N: sample<=d at N, FSM to CAPT, rd=0 after edge N.
REQ-022 CAPT, exactly one cycle: sample_valid=1, sample_cnt increments; FSM to RELEASE.
REQ-023 RELEASE: rd=0; FSM waits for d_ready=0, then moves to IDLE.
REQ-024 REQ with timeout counter = TIMEOUT_CYCLES-1 and d_ready=0: rd<=0, timeout_err<=1, FSM to RELEASE, sample unchanged.
REQ-025 d_ready=1 in the same cycle the timeout is reached: capture wins and no timeout is flagged.
REQ-026 Tick while the FSM is in REQ, CAPT or RELEASE: tick is dropped and overrun<=1; no request is queued.
REQ-027 err_clr=1 and a new error event in the same cycle: the error wins and the flag stays set.
REQ-028 rd never toggles high-low-high within one transaction; it remains high continuously in REQ.
REQ-029 sample_valid is never high for two consecutive cycles.
REQ-030 Latency from tick to rd=1 is 1 cycle; from d_ready sampled high to sample_valid is 1 cycle.

Reset
REQ-031 rst_l=0 immediately forces: FSM=IDLE, timer=0, timeout counter=0, rd=0, sample=16'h0000, sample_valid=0, sample_cnt=0, timeout_err=0, overrun=0, busy=0.
REQ-032 Reset asserted mid-transaction drops rd asynchronously; after release, the first read waits a full REFRESH_PERIOD.

Verification (bench uses REFRESH_PERIOD=10, TIMEOUT_CYCLES=8)
REQ-033 Normal read: en=1; responder raises d_ready with d=16'hA5C3 three cycles after rd -> rd falls 1 cycle later, sample=16'hA5C3, one sample_valid pulse, sample_cnt=1.
REQ-034 Timeout: responder never raises d_ready -> rd high for exactly 8 cycles, timeout_err=1, sample stays 16'h0000, next tick issues a new rd.
REQ-035 Slow release: d_ready held high 15 cycles after capture -> busy stays high, tick in that window sets overrun=1, no rd until d_ready=0 and the next tick.
REQ-036 Reset mid-REQ: rst_l low for 2 cycles while rd=1 -> rd=0 at once, all outputs at reset values, first rd 10 cycles after rst_l rises with en=1.
REQ-037 Count wrap: 256 successful reads -> sample_cnt reads 0 after read 256, with 256 sample_valid pulses total.
REQ-038 Simultaneous events: d_ready rises in the 8th REQ cycle -> capture occurs, timeout_err stays 0; err_clr asserted alongside an overrun tick -> overrun stays 1.

Source files
------------

// File: rtl/spi_read_sequencer_if.sv
// Signal bundle between the periodic read sequencer and its environment:
// control inputs, SPI reader handshake, captured data and status.
interface spi_read_sequencer_if;
  logic        en;
  logic        d_ready;
  logic [15:0] d;
  logic        err_clr;
  logic        rd;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;
  logic [7:0]  sample_cnt;
  logic        timeout_err;
  logic        overrun;

  modport master (
    input  en, d_ready, d, err_clr,
    output rd, sample, sample_valid, busy, sample_cnt, timeout_err, overrun
  );

  modport slave (
    output en, d_ready, d, err_clr,
    input  rd, sample, sample_valid, busy, sample_cnt, timeout_err, overrun
  );
endinterface

// File: rtl/spi_read_sequencer.sv
// Launches a read of an external SPI reader every REFRESH_PERIOD cycles, captures the
// returned word, and flags request timeouts and refresh ticks that arrive while busy.
module spi_read_sequencer #(
  parameter int unsigned REFRESH_PERIOD = 40_000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_l,
  spi_read_sequencer_if.master  bus
);

  localparam int unsigned TimerW = $clog2(REFRESH_PERIOD);
  localparam int unsigned ToutW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(REFRESH_PERIOD - 1);
  localparam logic [ToutW-1:0]  ToutMax  = ToutW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StCapt, StRelease} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [ToutW-1:0]  tout_q, tout_d;
  logic [15:0]       sample_q, sample_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              sample_valid_q, sample_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overrun_q, overrun_d;
  logic              tick;
  logic              tout_set;

  always_comb begin
    tick     = bus.en && (timer_q == TimerMax);
    timer_d  = (!bus.en || tick) ? '0 : timer_q + 1'b1;
    state_d  = state_q;
    tout_d   = '0;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    tout_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick) state_d = StReq;
      end
      StReq: begin
        // Data arriving on the last allowed cycle still counts as a capture.
        if (bus.d_ready) begin
          sample_d = bus.d;
          cnt_d    = cnt_q + 8'd1;
          state_d  = StCapt;
        end else if (tout_q == ToutMax) begin
          tout_set = 1'b1;
          state_d  = StRelease;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      StCapt: begin
        state_d = StRelease;
      end
      StRelease: begin
        if (!bus.d_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    rd_d           = (state_d == StReq);
    sample_valid_d = (state_d == StCapt);
    // A new error event outranks a simultaneous clear.
    timeout_err_d  = tout_set | (timeout_err_q & ~bus.err_clr);
    overrun_d      = (tick && (state_q != StIdle)) | (overrun_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      tout_q         <= '0;
      sample_q       <= 16'h0000;
      cnt_q          <= 8'd0;
      rd_q           <= 1'b0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      tout_q         <= tout_d;
      sample_q       <= sample_d;
      cnt_q          <= cnt_d;
      rd_q           <= rd_d;
      sample_valid_q <= sample_valid_d;
      timeout_err_q  <= timeout_err_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.rd           = rd_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.sample_cnt   = cnt_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_spi_read_sequencer.sv
// Directed bench for spi_read_sequencer: stimulus pushes expected words into a queue,
// a negedge monitor pops them on every sample_valid pulse and tracks sample_cnt.
module tb_spi_read_sequencer;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_read_sequencer_if bus ();

  spi_read_sequencer #(
    .REFRESH_PERIOD (10),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          pulses = 0;
  int          last_rise = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on sample_valid, count check one cycle later.
  initial begin
    logic [7:0]  exp_cnt;
    logic        cnt_pending;
    logic        prev_sv;
    logic [15:0] e;
    exp_cnt = 8'd0;
    cnt_pending = 1'b0;
    prev_sv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        exp_cnt = 8'd0;
        cnt_pending = 1'b0;
        prev_sv = 1'b0;
      end else begin
        if (cnt_pending) begin
          check("sample_cnt", 32'(bus.sample_cnt), 32'(exp_cnt));
          cnt_pending = 1'b0;
        end
        if (bus.sample_valid) begin
          check("sample_valid_gap", 32'(prev_sv), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_sample", 32'(bus.sample), 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("sample", 32'(bus.sample), 32'(e));
          end
          exp_cnt = exp_cnt + 8'd1;
          cnt_pending = 1'b1;
          pulses++;
        end
        prev_sv = bus.sample_valid;
      end
    end
  end

  task automatic wait_rd(output int t);
    int n;
    n = 0;
    while (!bus.rd && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rd_wait_expired", 32'(bus.rd), 32'd1);
    t = cyc;
  endtask

  // Waits for rd, answers after 'delay' REQ cycles; leaves d_ready high at return.
  task automatic do_read(input logic [15:0] data, input int delay, input int exp_gap);
    int t;
    wait_rd(t);
    if (exp_gap != 0) check("rd_period", 32'(t - last_rise), 32'(exp_gap));
    last_rise = t;
    repeat (delay - 1) @(negedge clk);
    check("rd_held", 32'(bus.rd), 32'd1);
    bus.d_ready = 1'b1;
    bus.d = data;
    exp_q.push_back(data);
    @(negedge clk);
    check("rd_fall", 32'(bus.rd), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_rd", 32'(bus.rd), 32'd0);
    check("rst_sample", 32'(bus.sample), 32'd0);
    check("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int t;
    int t_rel;
    int n;
    int p0;
    bus.en = 1'b0;
    bus.d_ready = 1'b0;
    bus.d = 16'h0000;
    bus.err_clr = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_values();
    rst_l = 1'b1;
    bus.en = 1'b1;
    t_rel = cyc;

    // Timeout: no response, rd high exactly 8 cycles.
    wait_rd(t);
    check("first_rd_latency", 32'(t - t_rel), 32'd10);
    last_rise = t;
    n = 0;
    while (bus.rd && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("rd_high_timeout", 32'(n), 32'd8);
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    check("sample_after_timeout", 32'(bus.sample), 32'd0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("timeout_err_clr", 32'(bus.timeout_err), 32'd0);

    // Normal read, answered three cycles after rd.
    do_read(16'hA5C3, 3, 10);
    bus.d_ready = 1'b0;

    // Slow release: d_ready held 15 cycles after capture.
    do_read(16'h3C96, 3, 10);
    repeat (15) @(negedge clk);
    check("slow_busy", 32'(bus.busy), 32'd1);
    check("slow_rd_low", 32'(bus.rd), 32'd0);
    check("slow_overrun", 32'(bus.overrun), 32'd1);
    bus.d_ready = 1'b0;
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("overrun_clr", 32'(bus.overrun), 32'd0);

    // Capture on the last REQ cycle; err_clr collides with an overrun tick.
    do_read(16'hBEEF, 8, 20);
    check("late_capture_no_timeout", 32'(bus.timeout_err), 32'd0);
    bus.d_ready = 1'b0;
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("overrun_beats_clr", 32'(bus.overrun), 32'd1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("overrun_clr2", 32'(bus.overrun), 32'd0);

    // Reset during REQ.
    wait_rd(t);
    check("rd_period_after_drop", 32'(t - last_rise), 32'd20);
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    t_rel = cyc;
    wait_rd(t);
    check("rd_latency_after_reset", 32'(t - t_rel), 32'd10);
    last_rise = t;

    // 256 reads: count wraps back to 0.
    p0 = pulses;
    for (int i = 0; i < 256; i++) begin
      do_read(16'(i * 257) ^ 16'h5A5A, 1, (i == 0) ? 0 : 10);
      bus.d_ready = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("cnt_wrap", 32'(bus.sample_cnt), 32'd0);
    check("pulse_total", 32'(pulses - p0), 32'd256);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
